// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the MMU dump path: the dump sequencer state
// encoding, the UART command byte that triggers a dump, and the default
// memory geometry used by the sequencer and serializer.
// ---------------------------------------------------------------------------
package mmu_pkg;

  // Command byte the MMU driver decodes as "dump memory range"
  localparam logic [7:0] CMD_DUMP = 8'h73;

  // Default geometry of the program/data memory seen through port B
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

  // Dump sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_TX   = 3'd3,
    ST_NX   = 3'd4,
    ST_DONE = 3'd5
  } dumpState_t;

endpackage : mmu_pkg

// File: rtl/mem_dump_ser.sv
// ---------------------------------------------------------------------------
// mem_dump_ser
// Word-to-byte serializer for the memory dump path. A word is loaded in one
// cycle and then presented MSB byte first on a valid/ready interface. Each
// accepted byte shifts the word left by eight bits and advances the byte
// counter; the counter wraps to zero after the last byte of the word.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_load       capture i_loadData and restart the byte count
//   i_loadData   memory word to serialize
//   i_active     sequencer is presenting bytes (drives o_txValid)
//   i_txReady    transmitter ready
//   o_txData     current byte (top byte of the shift register)
//   o_txValid    byte valid
//   o_handshake  byte accepted this cycle
//   o_lastByte   current byte is the last byte of the word
// ---------------------------------------------------------------------------
module mem_dump_ser
  import mmu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_loadData,
  input  logic              i_active,
  input  logic              i_txReady,
  output logic [7:0]        o_txData,
  output logic              o_txValid,
  output logic              o_handshake,
  output logic              o_lastByte
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_byteCnt;
  logic              w_handshake;
  logic              w_lastByte;

  assign w_handshake = i_active && i_txReady;
  assign w_lastByte  = (r_byteCnt == CNT_W'(NBYTES - 1));

  // Shift register and byte counter. A load always wins so that a fresh
  // word starts at byte zero even if a previous word was cut short by abort.
  // The data only moves on an accepted byte, which keeps o_txData stable
  // for as long as the transmitter stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_byteCnt <= '0;
    end else if (i_load) begin
      r_shift   <= i_loadData;
      r_byteCnt <= '0;
    end else if (w_handshake) begin
      r_shift   <= r_shift << 8;
      r_byteCnt <= w_lastByte ? '0 : r_byteCnt + CNT_W'(1);
    end
  end

  assign o_txData    = r_shift[DATA_W-1 -: 8];
  assign o_txValid   = i_active;
  assign o_handshake = w_handshake;
  assign o_lastByte  = w_lastByte;

endmodule : mem_dump_ser

// File: rtl/mem_dump_seq.sv
// ---------------------------------------------------------------------------
// mem_dump_seq
// Reads an inclusive word range from the program/data memory through port B
// and streams every word to the SPART transmitter as bytes, MSB first.
// Port B is only driven active while a dump is running; mem_web is tied low.
//
// Ports:
//   clk_100mhz    system clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse; latches the range and begins a dump
//   start_addr    first word address (inclusive)
//   stop_addr     last word address (inclusive)
//   abort         stops the dump at the next byte boundary
//   mem_enb       port-B enable
//   mem_web       port-B write enable (always 0)
//   mem_addrb     port-B address (holds while mem_enb is low)
//   mem_doutb     port-B read data, valid RD_LAT cycles after mem_enb
//   tx_data       byte to the transmitter
//   tx_valid      byte valid
//   tx_ready      transmitter ready
//   busy          dump in progress
//   done          one-cycle pulse on normal completion
//   aborted       one-cycle pulse when a dump ends through abort
//   err           one-cycle pulse when start is rejected (start_addr > stop_addr)
// ---------------------------------------------------------------------------
module mem_dump_seq
  import mmu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic              abort,
  output logic              mem_enb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addrb,
  input  logic [DATA_W-1:0] mem_doutb,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  dumpState_t        r_state;
  dumpState_t        w_nextState;
  logic [ADDR_W-1:0] r_curAddr;
  logic [ADDR_W-1:0] r_endAddr;
  logic [1:0]        r_waitCnt;
  logic              r_abort;
  logic              r_err;

  logic              w_startOk;
  logic              w_startBad;
  logic              w_abortSeen;
  logic              w_waitDone;
  logic              w_atEnd;
  logic              w_load;
  logic              w_txActive;
  logic              w_txValid;
  logic              w_txAccept;
  logic              w_lastByte;

  assign w_startOk   = start && (start_addr <= stop_addr);
  assign w_startBad  = start && (start_addr > stop_addr);
  assign w_abortSeen = r_abort || abort;
  assign w_waitDone  = (r_waitCnt == 2'(RD_LAT - 1));
  assign w_atEnd     = (r_curAddr == r_endAddr);
  assign w_txActive  = (r_state == ST_TX);

  // The read word is captured on the last wait cycle, unless an abort
  // means we are leaving for DONE instead of transmitting it.
  assign w_load = (r_state == ST_WT) && w_waitDone && !w_abortSeen;

  // State register
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Abort is honoured at byte boundaries only: in RD/WT
  // nothing is in flight, in TX only after the current byte is accepted,
  // and in NX before the next read is issued. The end-of-range test in NX
  // is done before incrementing, so a range ending at the top address
  // never wraps round to address zero.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_startOk) begin
          w_nextState = ST_RD;
        end
      end
      ST_RD: begin
        w_nextState = w_abortSeen ? ST_DONE : ST_WT;
      end
      ST_WT: begin
        if (w_abortSeen) begin
          w_nextState = ST_DONE;
        end else if (w_waitDone) begin
          w_nextState = ST_TX;
        end
      end
      ST_TX: begin
        if (w_txAccept) begin
          if (w_abortSeen) begin
            w_nextState = ST_DONE;
          end else if (w_lastByte) begin
            w_nextState = ST_NX;
          end
        end
      end
      ST_NX: begin
        if (w_abortSeen || w_atEnd) begin
          w_nextState = ST_DONE;
        end else begin
          w_nextState = ST_RD;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Range registers. They are only written when a dump is accepted from
  // IDLE, so a start pulse arriving mid-dump cannot disturb the range.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_curAddr <= '0;
      r_endAddr <= '0;
    end else if ((r_state == ST_IDLE) && w_startOk) begin
      r_curAddr <= start_addr;
      r_endAddr <= stop_addr;
    end else if ((r_state == ST_NX) && !w_abortSeen && !w_atEnd) begin
      r_curAddr <= r_curAddr + ADDR_W'(1);
    end
  end

  // Read latency counter, counting wait cycles since the RD cycle
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (r_state == ST_WT) begin
      r_waitCnt <= r_waitCnt + 2'd1;
    end else begin
      r_waitCnt <= '0;
    end
  end

  // Sticky abort. It collects abort while a dump is running, holds through
  // DONE to select the aborted pulse, and is cleared on the way into IDLE,
  // so an abort seen while idle never affects a later dump.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RD, ST_WT, ST_TX, ST_NX: r_abort <= r_abort || abort;
        default:                    r_abort <= 1'b0;
      endcase
    end
  end

  // Rejected start: a one-cycle error pulse, with no memory access
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_IDLE) && w_startBad;
    end
  end

  mem_dump_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .i_clk       (clk_100mhz),
    .i_rst_n     (rst_n),
    .i_load      (w_load),
    .i_loadData  (mem_doutb),
    .i_active    (w_txActive),
    .i_txReady   (tx_ready),
    .o_txData    (tx_data),
    .o_txValid   (w_txValid),
    .o_handshake (w_txAccept),
    .o_lastByte  (w_lastByte)
  );

  assign mem_enb   = (r_state == ST_RD);
  assign mem_web   = 1'b0;
  assign mem_addrb = r_curAddr;
  assign tx_valid  = w_txValid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE) && !r_abort;
  assign aborted   = (r_state == ST_DONE) && r_abort;
  assign err       = r_err;

endmodule : mem_dump_seq

// File: tb/tb_mem_dump_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_seq
// Directed bench for mem_dump_seq with a behavioural single-cycle-latency
// port-B memory. A negedge monitor logs accepted bytes, port-B reads and
// status pulses; each directed step compares that log with hand-computed
// expectations.
// ---------------------------------------------------------------------------
module tb_mem_dump_seq;

  typedef logic [7:0]  byteQ_t[$];
  typedef logic [13:0] addrQ_t[$];

  logic        clk_100mhz;
  logic        rst_n;
  logic        start;
  logic [13:0] start_addr;
  logic [13:0] stop_addr;
  logic        abort;
  logic        mem_enb;
  logic        mem_web;
  logic [13:0] mem_addrb;
  logic [31:0] mem_doutb;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        err;

  logic [31:0] mem [0:16383];

  logic [7:0]  rxBytes[$];
  logic [13:0] rdAddrs[$];
  int          doneCnt;
  int          abortCnt;
  int          errCnt;
  int          busyCnt;
  int          validCnt;
  int          webCnt;
  int          stallViol;
  logic        prevStall;
  logic [7:0]  prevData;

  int          byteBase;
  int          readBase;
  int          doneBase;
  int          abortBase;
  int          errBase;
  int          busyBase;
  int          validBase;

  int          checks;
  int          errors;

  mem_dump_seq #(
    .ADDR_W (14),
    .DATA_W (32),
    .RD_LAT (1)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .abort      (abort),
    .mem_enb    (mem_enb),
    .mem_web    (mem_web),
    .mem_addrb  (mem_addrb),
    .mem_doutb  (mem_doutb),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .err        (err)
  );

  // 100 MHz clock
  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  // Port-B memory with one cycle of read latency
  always @(posedge clk_100mhz) begin
    if (mem_enb) mem_doutb <= mem[mem_addrb];
  end

  // Negedge monitor: logs what the coming posedge will commit, and checks
  // that a stalled byte stays valid and unchanged on the next cycle
  initial begin
    doneCnt = 0; abortCnt = 0; errCnt = 0; busyCnt = 0;
    validCnt = 0; webCnt = 0; stallViol = 0;
    prevStall = 1'b0; prevData = 8'h00;
  end

  always @(negedge clk_100mhz) begin
    if (tx_valid && tx_ready) rxBytes.push_back(tx_data);
    if (mem_enb) rdAddrs.push_back(mem_addrb);
    if (mem_web) webCnt++;
    if (done) doneCnt++;
    if (aborted) abortCnt++;
    if (err) errCnt++;
    if (busy) busyCnt++;
    if (tx_valid) validCnt++;
    if (prevStall && (!tx_valid || (tx_data !== prevData))) stallViol++;
    prevStall = tx_valid && !tx_ready;
    prevData  = tx_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse start for the given range, then run until a status pulse is seen.
  // Optionally stalls tx_ready at random, pulses abort when byte abortAt of
  // this dump is on the bus, and fires a stray start at cycle restartAt.
  task automatic applyStimulus(input logic [13:0] sa, input logic [13:0] so,
                               input bit rndReady, input int abortAt, input int restartAt);
    bit finished;
    bit abortSent;
    byteBase  = rxBytes.size();
    readBase  = rdAddrs.size();
    doneBase  = doneCnt;
    abortBase = abortCnt;
    errBase   = errCnt;
    busyBase  = busyCnt;
    validBase = validCnt;
    finished  = 1'b0;
    abortSent = 1'b0;
    @(posedge clk_100mhz); #1;
    start_addr = sa; stop_addr = so; start = 1'b1;
    @(posedge clk_100mhz); #1;
    start = 1'b0; start_addr = 14'h0000; stop_addr = 14'h0000;
    for (int c = 0; c < 3000 && !finished; c++) begin
      tx_ready = rndReady ? ($urandom_range(0, 99) < 30) : 1'b1;
      start = (c == restartAt);
      abort = 1'b0;
      if (abortAt >= 0 && !abortSent && tx_valid && (rxBytes.size() - byteBase == abortAt)) begin
        abort = 1'b1;
        abortSent = 1'b1;
      end
      @(negedge clk_100mhz);
      if (done || aborted || err) finished = 1'b1;
      @(posedge clk_100mhz); #1;
      start = 1'b0;
    end
    checkOutput("run_finished", 32'(finished), 32'd1);
    tx_ready = 1'b1;
    abort = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic checkRun(input string tag, input byteQ_t expBytes, input addrQ_t expReads,
                          input int expDone, input int expAbort, input int expErr, input int expBusy);
    int nB;
    int nR;
    nB = rxBytes.size() - byteBase;
    nR = rdAddrs.size() - readBase;
    checkOutput({tag, " byte_count"}, 32'(nB), 32'(expBytes.size()));
    for (int i = 0; i < expBytes.size(); i++) begin
      if (i < nB) checkOutput({tag, " byte"}, 32'(rxBytes[byteBase + i]), 32'(expBytes[i]));
    end
    checkOutput({tag, " read_count"}, 32'(nR), 32'(expReads.size()));
    for (int i = 0; i < expReads.size(); i++) begin
      if (i < nR) checkOutput({tag, " read_addr"}, 32'(rdAddrs[readBase + i]), 32'(expReads[i]));
    end
    checkOutput({tag, " done_pulses"}, 32'(doneCnt - doneBase), 32'(expDone));
    checkOutput({tag, " aborted_pulses"}, 32'(abortCnt - abortBase), 32'(expAbort));
    checkOutput({tag, " err_pulses"}, 32'(errCnt - errBase), 32'(expErr));
    if (expBusy >= 0) checkOutput({tag, " busy_cycles"}, 32'(busyCnt - busyBase), 32'(expBusy));
    checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  // Directed sequence
  initial begin
    byteQ_t expB;
    byteQ_t noBytes;
    addrQ_t expR;
    addrQ_t noReads;
    bit     reached;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    start_addr = 14'h0000; stop_addr = 14'h0000;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    for (int i = 0; i < 5; i++) mem[12 + i] = 32'h11223344 + 32'(i);
    mem[5]      = 32'hDEADBEEF;
    mem[0]      = 32'h01020304;
    mem[1]      = 32'hA0B1C2D3;
    mem[2]      = 32'h55AA00FF;
    mem[3]      = 32'h89ABCDEF;
    mem[16382]  = 32'hCAFEF00D;
    mem[16383]  = 32'h0BADC0DE;

    $display("[TB] reset state");
    #12;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst mem_enb", 32'(mem_enb), 32'd0);
    checkOutput("rst mem_addrb", 32'(mem_addrb), 32'd0);
    checkOutput("rst tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    @(posedge clk_100mhz); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_100mhz);
    #1;

    $display("[TB] T1 range 12..16, stray start mid-dump");
    applyStimulus(14'd12, 14'd16, 1'b0, -1, 10);
    expB = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h45,
             8'h11, 8'h22, 8'h33, 8'h46, 8'h11, 8'h22, 8'h33, 8'h47,
             8'h11, 8'h22, 8'h33, 8'h48};
    expR = '{14'd12, 14'd13, 14'd14, 14'd15, 14'd16};
    checkRun("T1", expB, expR, 1, 0, 0, 36);

    $display("[TB] T2 single word 5..5");
    applyStimulus(14'd5, 14'd5, 1'b0, -1, -1);
    expB = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    expR = '{14'd5};
    checkRun("T2", expB, expR, 1, 0, 0, 8);

    $display("[TB] T3 rejected start 9..4");
    applyStimulus(14'd9, 14'd4, 1'b0, -1, -1);
    checkRun("T3", noBytes, noReads, 0, 0, 1, 0);
    checkOutput("T3 valid_cycles", 32'(validCnt - validBase), 32'd0);

    $display("[TB] T4 range 0..3 with random tx_ready");
    applyStimulus(14'd0, 14'd3, 1'b1, -1, -1);
    expB = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB1, 8'hC2, 8'hD3,
             8'h55, 8'hAA, 8'h00, 8'hFF, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    expR = '{14'd0, 14'd1, 14'd2, 14'd3};
    checkRun("T4", expB, expR, 1, 0, 0, -1);
    checkOutput("T4 stall_stable", 32'(stallViol), 32'd0);

    $display("[TB] T5 abort on second byte of word 13");
    applyStimulus(14'd12, 14'd16, 1'b0, 5, -1);
    expB = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    expR = '{14'd12, 14'd13};
    checkRun("T5", expB, expR, 0, 1, 0, 12);

    $display("[TB] T6 normal dump after abort");
    applyStimulus(14'd5, 14'd5, 1'b0, -1, -1);
    expB = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    expR = '{14'd5};
    checkRun("T6", expB, expR, 1, 0, 0, 8);

    $display("[TB] T7 top of memory 0x3FFE..0x3FFF");
    applyStimulus(14'h3FFE, 14'h3FFF, 1'b0, -1, -1);
    expB = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0B, 8'hAD, 8'hC0, 8'hDE};
    expR = '{14'h3FFE, 14'h3FFF};
    checkRun("T7", expB, expR, 1, 0, 0, 15);

    $display("[TB] T8 reset during transmit");
    byteBase  = rxBytes.size();
    doneBase  = doneCnt;
    abortBase = abortCnt;
    @(posedge clk_100mhz); #1;
    start_addr = 14'd12; stop_addr = 14'd16; start = 1'b1;
    @(posedge clk_100mhz); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (tx_valid && (rxBytes.size() - byteBase >= 2)) reached = 1'b1;
      else begin
        @(posedge clk_100mhz); #1;
      end
    end
    checkOutput("T8 reached_tx", 32'(reached), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("T8 busy", 32'(busy), 32'd0);
    checkOutput("T8 tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("T8 tx_data", 32'(tx_data), 32'd0);
    checkOutput("T8 mem_enb", 32'(mem_enb), 32'd0);
    checkOutput("T8 mem_addrb", 32'(mem_addrb), 32'd0);
    checkOutput("T8 status", 32'({done, aborted, err}), 32'd0);
    repeat (2) @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk_100mhz);
    #1;
    checkOutput("T8 idle_busy", 32'(busy), 32'd0);
    checkOutput("T8 done_pulses", 32'(doneCnt - doneBase), 32'd0);
    checkOutput("T8 aborted_pulses", 32'(abortCnt - abortBase), 32'd0);
    checkOutput("web_never_high", 32'(webCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_dump_seq

// File: doc/mem_dump_seq.md
Name: mem_dump_seq

Overview:
- Sequencer that reads an inclusive word range from the on-chip program/data memory through port B and streams each word out as bytes to the SPART transmitter.
- Sits inside the MMU, beside the existing driver. It is started once the driver has decoded a dump command and latched the start/stop addresses.
- It owns port B (enb/web/addrb) only while busy. At all other times it drives that port idle.

Parameters:
- ADDR_W, 14, memory word-address width.
- DATA_W, 32, memory word width; must be a multiple of 8.
- RD_LAT, 1, port-B read latency in cycles (1 or 2).

Ports:
- clk_100mhz  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches start_addr/stop_addr and begins a dump
- start_addr  input  ADDR_W  first word address (inclusive)
- stop_addr  input  ADDR_W  last word address (inclusive)
- abort  input  1  level/pulse; terminates the dump at the next byte boundary
- mem_enb  output  1  port-B enable
- mem_web  output  1  port-B write enable; always 0 from this block
- mem_addrb  output  ADDR_W  port-B address
- mem_doutb  input  DATA_W  port-B read data, valid RD_LAT cycles after enb
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  byte valid
- tx_ready  input  1  transmitter accepts the byte when tx_valid and tx_ready are both high
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse when the range completes normally
- aborted  output  1  one-cycle pulse when a dump ends via abort
- err  output  1  one-cycle pulse when start is rejected because start_addr > stop_addr

Behaviour:
- Reset values (asynchronous, rst_n=0): state IDLE; all outputs 0; internal address, byte count and shift register 0.
- Reset mid-dump returns to IDLE immediately; no done or aborted pulse.

States:
- IDLE: waits for start.
  - start with start_addr<=stop_addr: latch cur_addr=start_addr and end_addr=stop_addr; go to RD.
  - start with start_addr>stop_addr: err=1 for one cycle, stay IDLE, no memory access.
- RD: mem_enb=1, mem_addrb=cur_addr, for exactly one cycle; go to WT.
- WT: wait RD_LAT cycles counted from the RD cycle. On the final cycle capture mem_doutb into the shift register; go to TX. mem_enb=0 throughout.
- TX: tx_valid=1, tx_data = shift register [DATA_W-1:DATA_W-8] (MSB byte first).
  - On handshake: shift left 8 and increment the byte count.
  - After DATA_W/8 bytes, go to NX.
  - tx_valid stays high and tx_data stays stable until the handshake; no byte is ever dropped or duplicated.
- NX: one cycle.
  - If abort was seen: go to DONE (abort).
  - Else if cur_addr==end_addr: go to DONE (normal). The compare is made before incrementing, so end_addr = 2^ADDR_W-1 must not wrap.
  - Else cur_addr+1; go to RD.
- DONE: one cycle; pulse done or aborted; busy drops next cycle; go to IDLE.

Abort and start rules:
- abort is sticky-latched while busy and cleared on IDLE entry.
- abort is sampled at the byte boundary: after any handshake in TX, or in RD/WT, the sequencer goes straight to DONE (abort) once the in-flight byte, if any, is accepted.
- abort in IDLE is ignored.
- start while busy is ignored; the latched addresses do not change.

Port-B and throughput rules:
- mem_addrb holds its last value when enb=0; mem_web is constant 0.
- Throughput with tx_ready tied high: DATA_W/8 + RD_LAT + 2 cycles per word.

Decomposition:
- Shared package (mmu_pkg): state encoding enum; the dump command byte constant CMD_DUMP=8'h73; ADDR_W/DATA_W defaults.
- One natural sub-module: mem_dump_ser, the DATA_W-to-byte shift register with valid/ready and byte counter. The FSM stays in mem_dump_seq.

Test Plan:
- Memory words 12..16 preloaded 0x11223344+i; start 12/16; tx_ready=1 -> 20 bytes 11 22 33 44 11 22 33 45 … 11 22 33 48; reads at addresses 12,13,14,15,16 in order; done pulse once; busy low after.
- start_addr=stop_addr=5, mem[5]=0xDEADBEEF -> bytes DE AD BE EF, exactly one mem_enb pulse, done.
- start_addr=9, stop_addr=4 -> err pulse, busy stays 0, no mem_enb, no tx_valid.
- Random tx_ready (about 30% duty) over range 0..3 -> byte stream identical to the no-stall case; tx_data stable while tx_valid && !tx_ready.
- abort asserted during the 2nd byte of word 13 in a 12..16 dump -> that byte completes, no further bytes or reads, aborted pulse, no done; a following start works normally.
- Range 0x3FFE..0x3FFF -> 8 bytes then done, no read of address 0; rst_n low mid-TX -> all outputs 0 immediately, IDLE.
